// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencing controller for the five-stage core.
//
// Drives the write enables and NOP-insert (flush) controls of the PC register and the
// IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers from hazard, branch and memory
// stall inputs. A HALT reaching ID starts a drain; once HALT has travelled to WB the
// pipeline freezes until reset.
//
// Optional feature: define PIPE_CTRL_STALLCNT_EN to build the RUN-state stall counter;
// otherwise stall_cycles is tied to zero.
//
// Parameters:
//   DRAIN_CYC     advancing cycles after DRAIN entry before HALTED (1..3)
// Ports:
//   clk           core clock
//   rst           synchronous active-low reset
//   load_use      load-use hazard detected in ID
//   br_taken      branch/jump in EX redirects PC
//   halt_id       HALT instruction present in ID
//   imem_stall    instruction fetch not complete this cycle
//   dmem_stall    data access not complete this cycle
//   en_*          register write enables (PC, IF/ID, ID/EX, EX/MEM, MEM/WB)
//   flush_ifid/_idex  load a NOP when high together with the matching enable
//   halted        pipeline drained and frozen
//   state         FSM state: RUN=00, DRAIN=01, HALTED=10
//   err           sticky illegal-state flag
//   stall_cycles  RUN-state PC stall counter (zero when the feature is off)
module pipe_ctrl #(
   parameter int unsigned DRAIN_CYC = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_use,
   input  logic        br_taken,
   input  logic        halt_id,
   input  logic        imem_stall,
   input  logic        dmem_stall,
   output logic        en_pc,
   output logic        en_ifid,
   output logic        en_idex,
   output logic        en_exmem,
   output logic        en_memwb,
   output logic        flush_ifid,
   output logic        flush_idex,
   output logic        halted,
   output logic [1:0]  state,
   output logic        err,
   output logic [15:0] stall_cycles
);

   typedef enum logic [1:0] {
      StRun     = 2'b00,
      StDrain   = 2'b01,
      StHalted  = 2'b10,
      StIllegal = 2'b11
   } state_e;

   localparam logic [1:0] DrainLoad = 2'(DRAIN_CYC);

   state_e     state_q, state_d;
   logic [1:0] cnt_q, cnt_d;
   logic       err_q, err_d;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      err_d      = err_q;
      en_pc      = 1'b0;
      en_ifid    = 1'b0;
      en_idex    = 1'b0;
      en_exmem   = 1'b0;
      en_memwb   = 1'b0;
      flush_ifid = 1'b0;
      flush_idex = 1'b0;

      if (!rst) begin
         // Every register loads a NOP while reset is held.
         en_pc      = 1'b1;
         en_ifid    = 1'b1;
         en_idex    = 1'b1;
         en_exmem   = 1'b1;
         en_memwb   = 1'b1;
         flush_ifid = 1'b1;
         flush_idex = 1'b1;
      end else begin
         unique case (state_q)
            StRun: begin
               if (dmem_stall) begin
                  // Whole pipeline frozen; defaults already zero.
               end else if (br_taken) begin
                  // Squash IF/ID and ID/EX; a same-cycle HALT in ID is discarded.
                  en_pc      = 1'b1;
                  en_ifid    = 1'b1;
                  en_idex    = 1'b1;
                  en_exmem   = 1'b1;
                  en_memwb   = 1'b1;
                  flush_ifid = 1'b1;
                  flush_idex = 1'b1;
               end else if (load_use) begin
                  // Hold PC and IF/ID, bubble into ID/EX.
                  en_idex    = 1'b1;
                  flush_idex = 1'b1;
                  en_exmem   = 1'b1;
                  en_memwb   = 1'b1;
               end else begin
                  // Normal advance; halt and imem stall both stop fetch and feed NOPs.
                  en_pc    = !(halt_id || imem_stall);
                  en_ifid  = 1'b1;
                  en_idex  = 1'b1;
                  en_exmem = 1'b1;
                  en_memwb = 1'b1;
                  flush_ifid = halt_id || imem_stall;
                  if (halt_id) begin
                     state_d = StDrain;
                     cnt_d   = DrainLoad;
                  end
               end
            end
            StDrain: begin
               if (!dmem_stall) begin
                  en_ifid    = 1'b1;
                  flush_ifid = 1'b1;
                  en_idex    = 1'b1;
                  en_exmem   = 1'b1;
                  en_memwb   = 1'b1;
                  if (cnt_q == 2'd0) begin
                     state_d = StHalted;
                  end else begin
                     cnt_d = cnt_q - 2'd1;
                  end
               end
            end
            StHalted: begin
               // Frozen until reset.
            end
            StIllegal: begin
               state_d = StHalted;
               err_d   = 1'b1;
            end
            default: begin
               state_d = StHalted;
               err_d   = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= StRun;
         cnt_q   <= 2'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign state  = state_q;
   assign halted = state_q[1];  // HALTED and the illegal state both present as halted
   assign err    = err_q;

`ifdef PIPE_CTRL_STALLCNT_EN
   logic [15:0] stall_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         stall_q <= 16'h0000;
      end else if (state_q == StRun && !en_pc && stall_q != 16'hFFFF) begin
         stall_q <= stall_q + 16'd1;
      end
   end

   assign stall_cycles = stall_q;
`else
   assign stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios followed by random stimulus,
// compared each cycle against a behavioural model of the sequencing rules.
module tb_pipe_ctrl;

   localparam int unsigned DRAIN_CYC = 2;

   logic        clk = 1'b0;
   logic        rst, load_use, br_taken, halt_id, imem_stall, dmem_stall;
   logic        en_pc, en_ifid, en_idex, en_exmem, en_memwb;
   logic        flush_ifid, flush_idex, halted, err;
   logic [1:0]  state;
   logic [15:0] stall_cycles;

   always #5 clk = ~clk;

   pipe_ctrl #(.DRAIN_CYC(DRAIN_CYC)) dut (
      .clk          (clk),
      .rst          (rst),
      .load_use     (load_use),
      .br_taken     (br_taken),
      .halt_id      (halt_id),
      .imem_stall   (imem_stall),
      .dmem_stall   (dmem_stall),
      .en_pc        (en_pc),
      .en_ifid      (en_ifid),
      .en_idex      (en_idex),
      .en_exmem     (en_exmem),
      .en_memwb     (en_memwb),
      .flush_ifid   (flush_ifid),
      .flush_idex   (flush_idex),
      .halted       (halted),
      .state        (state),
      .err          (err),
      .stall_cycles (stall_cycles)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   // Model: mode 0=running, 1=draining, 2=halted; left = advancing drain cycles still
   // owed before the freeze.
   int mode   = 0;
   int left   = 0;
   int stalls = 0;
   bit known  = 1'b0;

   task automatic step(input bit r, input bit lu, input bit br, input bit h,
                       input bit is, input bit ds);
      logic [4:0] exp_en;
      logic [1:0] exp_fl;
      int         exp_stall;
      rst = r; load_use = lu; br_taken = br; halt_id = h; imem_stall = is; dmem_stall = ds;
      #4;
      // exp_en = {pc, ifid, idex, exmem, memwb}; exp_fl = {ifid, idex}
      if (!r)                    begin exp_en = 5'b11111; exp_fl = 2'b11; end
      else if (mode == 2)        begin exp_en = 5'b00000; exp_fl = 2'b00; end
      else if (ds)               begin exp_en = 5'b00000; exp_fl = 2'b00; end
      else if (mode == 1)        begin exp_en = 5'b01111; exp_fl = 2'b10; end
      else if (br)               begin exp_en = 5'b11111; exp_fl = 2'b11; end
      else if (lu)               begin exp_en = 5'b00111; exp_fl = 2'b01; end
      else if (h || is)          begin exp_en = 5'b01111; exp_fl = 2'b10; end
      else                       begin exp_en = 5'b11111; exp_fl = 2'b00; end

      check("en", {27'd0, en_pc, en_ifid, en_idex, en_exmem, en_memwb}, {27'd0, exp_en});
      check("flush", {30'd0, flush_ifid, flush_idex}, {30'd0, exp_fl});
      if (known) begin
`ifdef PIPE_CTRL_STALLCNT_EN
         exp_stall = stalls;
`else
         exp_stall = 0;
`endif
         check("state", {30'd0, state}, mode);
         check("halted", {31'd0, halted}, {31'd0, mode == 2});
         check("err", {31'd0, err}, 0);
         check("stall_cycles", {16'd0, stall_cycles}, exp_stall);
      end

      if (!r) begin
         mode = 0; left = 0; stalls = 0; known = 1'b1;
      end else if (mode == 0) begin
         if (!exp_en[4] && stalls < 65535) stalls++;
         if (!ds && !br && !lu && h) begin
            mode = 1;
            left = DRAIN_CYC;
         end
      end else if (mode == 1 && !ds) begin
         if (left == 0) mode = 2;
         else left--;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0);
   endtask

   initial begin
      int t0;
      int lat;
      rst = 1'b0; load_use = 0; br_taken = 0; halt_id = 0; imem_stall = 0; dmem_stall = 0;
      @(posedge clk);
      #1;
      // Reset then idle
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      idle(3);
      // Load-use single cycle
      step(1, 1, 0, 0, 0, 0);
      idle(2);
      // Load-use with imem stall, imem stall alone
      step(1, 1, 0, 0, 1, 0);
      step(1, 0, 0, 0, 1, 0);
      idle(1);
      // Branch squashes a same-cycle halt
      step(1, 0, 1, 1, 0, 0);
      idle(3);
      // Stall priority
      step(1, 1, 0, 0, 1, 1);
      step(1, 1, 1, 1, 1, 1);
      idle(1);
      // Halt drain with a dmem stall in cycle 2; halted expected at cycle 5
      step(1, 0, 0, 1, 0, 0);
      step(1, 1, 1, 1, 1, 0);
      step(1, 0, 0, 0, 0, 1);
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      check("halted_cycle5", {31'd0, halted}, 1);
      idle(3);
      // Reset mid-drain, then a clean drain with measured latency
      step(0, 0, 0, 0, 0, 0);
      idle(2);
      step(1, 0, 0, 1, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      idle(2);
      step(1, 0, 0, 1, 0, 0);
      lat = 1;
      t0 = 0;
      while (!halted && t0 < 20) begin
         idle(1);
         lat++;
         t0++;
      end
      check("halt_latency", lat, DRAIN_CYC + 2);
      // Random stimulus
      for (int i = 0; i < 1500; i++) begin
         step($urandom_range(0, 99) >= 3,
              $urandom_range(0, 99) < 15,
              $urandom_range(0, 99) < 10,
              $urandom_range(0, 99) < 4,
              $urandom_range(0, 99) < 20,
              $urandom_range(0, 99) < 20);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
